timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised successor to the fixed two-timer OPL3 timer block. It provides `NUM_TIMERS` up-counting interval timers, each with its own power-of-two prescale, per-timer one-shot/auto-reload mode, start, mask and overflow flag, plus an aggregated interrupt and a status byte for `host_if` reads. It sits beside `register_file` in the `opl3` top level, clocked by `clk` and paced by `sample_clk_en` from `clk_div`.

## Interface

Parameters:
- `NUM_TIMERS`, default 2, number of timers; legal range 1..6.
- `TIMER_WIDTH`, default 8, counter and reload width.
- `BASE_DIV_LOG2`, default 2, log2 of the `sample_clk_en` pulses per tick for timer 0.
- `STEP_LOG2`, default 2, extra log2 divide for each successive timer. Timer i divides by 2^(`BASE_DIV_LOG2` + i·`STEP_LOG2`).
- `STATUS_WIDTH`, default 8, width of `status`.

Ports:
- `clk`, in, 1: OPL3 clock.
- `reset`, in, 1: synchronous, active-high.
- `sample_clk_en`, in, 1: one-cycle sample strobe.
- `reload`, in, [NUM_TIMERS][TIMER_WIDTH]: preset value per timer.
- `st`, in, [NUM_TIMERS]: start/run level per timer.
- `mt`, in, [NUM_TIMERS]: mask per timer; while high, the flag is held clear.
- `one_shot`, in, [NUM_TIMERS]: 1 = stop after the first overflow; 0 = auto-reload.
- `irq_rst`, in, 1: single-cycle pulse that clears all flags.
- `ft`, out, [NUM_TIMERS]: overflow flags.
- `irq`, out, 1: OR of `ft`.
- `irq_n`, out, 1: inverse of `irq`.
- `status`, out, STATUS_WIDTH: bit 7 = `irq`; bit 6−i = `ft[i]`; all other bits 0.

## Operation

- **Prescaler:** free-running counter of width `BASE_DIV_LOG2` + (`NUM_TIMERS`−1)·`STEP_LOG2`. It increments on each `sample_clk_en` and wraps naturally. `tick[i]` is asserted in a `sample_clk_en` cycle when the prescaler's low (`BASE_DIV_LOG2` + i·`STEP_LOG2`) bits are all ones.
- **Per-timer state:** `count`, `running`, `st_q` (last `st`).
- **Start:** on an `st[i]` rising edge (`st[i]` = 1, `st_q` = 0), load `count` ← `reload[i]` and set `running` ← 1. A tick in that same cycle is ignored for that timer.
- **Stop:** `st[i]` = 0 sets `running` ← 0; `count` holds.
- **Tick while running:**
  - If `count` ≠ all-ones, `count` ← `count` + 1.
  - If `count` = all-ones, this is an overflow. `count` ← `reload[i]`, and the flag is set if `mt[i]` = 0. If `one_shot[i]` = 1, `running` ← 0; restart then requires `st[i]` to go low and high again.
- **Reload semantics:** `reload` is sampled only at start and at overflow. Changing it mid-count has no effect until the next overflow.
- **Flag priority:** `irq_rst` > `mt[i]` > overflow set > hold. A simultaneous overflow and `irq_rst` leaves the flag clear. Flags are sticky otherwise.
- **Interrupt:** `irq` = OR over `ft`. It is registered from the flag next-state so that it changes on the same edge as `ft`. `irq_n` = ~`irq`.
- **Overflow with no set:** with `mt[i]` = 1, overflows still reload and still obey `one_shot`, but never set the flag.

## Timing

- **Reset values:** all `count` 0, prescaler 0, `running` 0, `st_q` 0, `ft` 0, `irq` 0, `irq_n` 1, `status` 0.
- **Reset mid-count:** reset aborts everything. A held-high `st` after reset is treated as a new rising edge.
- **Flag latency:** `ft`, `irq`, `irq_n` and `status` update on the clock edge that ends the overflow tick cycle (1-cycle latency).
- **Clear latency:** `irq_rst` clears on the following edge.
- **`count` = all-ones reload:** overflows on every tick.
- **Tick schedule:** with defaults, timer 0 ticks every 4 `sample_clk_en` pulses and timer 1 every 16 (80 µs / 320 µs at 49.7 kHz). The first tick occurs at the 4th (respectively 16th) pulse after reset.
- **Independence:** timers are fully independent. Simultaneous overflows set multiple flags on the same edge.

## Test plan

1. **Basic overflow:** Reset, then `reload[0]` = 8'hFE, `st[0]` = 1, `mt` = 0, `one_shot` = 0. Drive `sample_clk_en` every 4 clocks.
   - `ft[0]` rises 1 cycle after the 8th pulse.
   - `status` = 8'hC0, `irq_n` = 0.
   - It overflows again after 8 more pulses.
2. **Clear and mask:** After scenario 1, pulse `irq_rst` → `ft` = 0, `status` = 8'h00 next cycle. Then set `mt[0]` = 1 → no flag on later overflows, but `count` still reloads to 8'hFE.
3. **One-shot and restart:** `one_shot[1]` = 1, `reload[1]` = 8'hFF, `st[1]` = 1.
   - `ft[1]` sets at the 16th pulse and `status` = 8'hA0.
   - `count` then stays 8'hFF and no further overflow occurs.
   - Toggling `st[1]` 0→1 restarts it.
4. **Priority:** Align `irq_rst` with an overflow tick cycle → flag stays 0. `irq_rst` one cycle later → flag cleared after being 1 for exactly one cycle.
5. **Reset mid-count:** Assert `reset` with `count` = 8'h80 and `ft` = 2'b01 → all outputs return to reset values. With `st[0]` still high, reload occurs on the first cycle after reset.
6. **Scaling:** Set `NUM_TIMERS` = 4, `TIMER_WIDTH` = 10, `reload` = 10'h3FF for all timers → timers 0..3 overflow at pulses 4, 16, 64 and 256, setting `status` bits 6, 5, 4 and 3.

Source files
------------

// File: rtl/timer_bank.sv
// timer_bank: NUM_TIMERS up-counting interval timers with per-timer power-of-two prescale, one-shot/auto-reload, mask and sticky overflow flags
// Ports: clk/reset (sync, active-high); sample_clk_en paces the shared prescaler;
//   reload/st/mt/one_shot are per-timer preset, run level, flag mask and one-shot select;
//   irq_rst clears all flags; ft = flags, irq/irq_n = OR of flags, status = {irq, ft[0], ft[1], ...} from bit 7 down.
module timer_bank #(
  parameter int NUM_TIMERS = 2,
  parameter int TIMER_WIDTH = 8,
  parameter int BASE_DIV_LOG2 = 2,
  parameter int STEP_LOG2 = 2,
  parameter int STATUS_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  sample_clk_en,
  input  logic [NUM_TIMERS-1:0][TIMER_WIDTH-1:0] reload,
  input  logic [NUM_TIMERS-1:0]                 st,
  input  logic [NUM_TIMERS-1:0]                 mt,
  input  logic [NUM_TIMERS-1:0]                 one_shot,
  input  logic                                  irq_rst,
  output logic [NUM_TIMERS-1:0]                 ft,
  output logic                                  irq,
  output logic                                  irq_n,
  output logic [STATUS_WIDTH-1:0]               status
);
  localparam int PW = BASE_DIV_LOG2 + (NUM_TIMERS - 1) * STEP_LOG2;
  localparam int PWC = PW < 1 ? 1 : PW;
  logic [PWC-1:0] presc_q, presc_d;
  logic [NUM_TIMERS-1:0][TIMER_WIDTH-1:0] count_q, count_d;
  logic [NUM_TIMERS-1:0] run_q, run_d, st_q, ft_q, ft_d;
  logic [NUM_TIMERS-1:0] rise, tick, adv, ovf;
  logic irq_q;
  // Low-bit mask whose all-ones pattern marks a tick for timer k.
  function automatic logic [PWC-1:0] tmask(input int k);
    tmask = PWC'((64'd1 << (BASE_DIV_LOG2 + k * STEP_LOG2)) - 64'd1);
  endfunction
  always_comb begin
    presc_d = sample_clk_en ? presc_q + 1'b1 : presc_q;
    rise = '0;
    tick = '0;
    adv = '0;
    ovf = '0;
    count_d = count_q;
    run_d = '0;
    ft_d = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      rise[i] = st[i] & ~st_q[i];
      tick[i] = sample_clk_en && ((presc_q & tmask(i)) == tmask(i));
      // A start edge wins over a coincident tick.
      adv[i] = st[i] && !rise[i] && run_q[i] && tick[i];
      ovf[i] = adv[i] && (&count_q[i]);
      count_d[i] = (rise[i] || ovf[i]) ? reload[i] : adv[i] ? count_q[i] + 1'b1 : count_q[i];
      run_d[i] = rise[i] || (st[i] && run_q[i] && !(ovf[i] && one_shot[i]));
      ft_d[i] = (irq_rst || mt[i]) ? 1'b0 : (ovf[i] || ft_q[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= '0;
      run_q <= '0;
      st_q <= '0;
      ft_q <= '0;
      irq_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      run_q <= run_d;
      st_q <= st;
      ft_q <= ft_d;
      // Taken from the flag next-state so irq moves on the same edge as ft.
      irq_q <= |ft_d;
    end
  end
  always_comb begin
    status = '0;
    status[7] = irq_q;
    for (int i = 0; i < NUM_TIMERS; i++) status[6-i] = ft_q[i];
  end
  assign ft = ft_q;
  assign irq = irq_q;
  assign irq_n = ~irq_q;
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed checks of timer_bank (default 2x8 instance and a 4x10 scaled instance)
module tb_timer_bank;
  logic clk = 0, reset = 1, en = 0, irq_rst = 0;
  logic [1:0][7:0] reload = '0;
  logic [1:0] st = '0, mt = '0, one_shot = '0, ft;
  logic irq, irq_n;
  logic [7:0] status;
  logic r4 = 1, en4 = 0, irq_rst4 = 0;
  logic [3:0][9:0] reload4 = {4{10'h3FF}};
  logic [3:0] st4 = '0, mt4 = '0, os4 = '0, ft4;
  logic irq4, irq_n4;
  logic [7:0] status4;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  timer_bank dut (
    .clk(clk), .reset(reset), .sample_clk_en(en), .reload(reload), .st(st), .mt(mt),
    .one_shot(one_shot), .irq_rst(irq_rst), .ft(ft), .irq(irq), .irq_n(irq_n), .status(status)
  );
  timer_bank #(.NUM_TIMERS(4), .TIMER_WIDTH(10)) dut4 (
    .clk(clk), .reset(r4), .sample_clk_en(en4), .reload(reload4), .st(st4), .mt(mt4),
    .one_shot(os4), .irq_rst(irq_rst4), .ft(ft4), .irq(irq4), .irq_n(irq_n4), .status(status4)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulses(input int n);
    repeat (n) begin
      en = 1;
      cyc(1);
      en = 0;
      cyc(3);
    end
  endtask
  initial begin
    cyc(2);
    check("rst_ft", ft, 0);
    check("rst_irq", irq, 0);
    check("rst_irq_n", irq_n, 1);
    check("rst_status", status, 0);
    check("rst_count", dut.count_q[0], 0);
    reset = 0;
    reload[0] = 8'hFE;
    st[0] = 1;
    cyc(1);
    check("start_load", dut.count_q[0], 8'hFE);
    pulses(7);
    check("pre_ovf_ft", ft, 0);
    check("pre_ovf_count", dut.count_q[0], 8'hFF);
    pulses(1);
    check("ovf_ft", ft, 2'b01);
    check("ovf_status", status, 8'hC0);
    check("ovf_irq_n", irq_n, 0);
    check("ovf_reload", dut.count_q[0], 8'hFE);
    pulses(4);
    check("second_half", dut.count_q[0], 8'hFF);
    pulses(4);
    check("second_ovf", dut.count_q[0], 8'hFE);
    irq_rst = 1;
    cyc(1);
    irq_rst = 0;
    check("clr_ft", ft, 0);
    check("clr_status", status, 8'h00);
    check("clr_irq_n", irq_n, 1);
    mt[0] = 1;
    pulses(8);
    check("mask_ft", ft, 0);
    check("mask_reload", dut.count_q[0], 8'hFE);
    mt[0] = 0;
    st[0] = 0;
    one_shot[1] = 1;
    reload[1] = 8'hFF;
    st[1] = 1;
    cyc(1);
    check("os_load", dut.count_q[1], 8'hFF);
    pulses(7);
    check("os_pre", ft, 0);
    pulses(1);
    check("os_ft", ft, 2'b10);
    check("os_status", status, 8'hA0);
    check("stop_hold", dut.count_q[0], 8'hFE);
    irq_rst = 1;
    cyc(1);
    irq_rst = 0;
    pulses(16);
    check("os_no_second", ft, 0);
    check("os_count_hold", dut.count_q[1], 8'hFF);
    st[1] = 0;
    cyc(1);
    st[1] = 1;
    cyc(1);
    pulses(16);
    check("os_restart", ft, 2'b10);
    irq_rst = 1;
    cyc(1);
    irq_rst = 0;
    reload[0] = 8'hFF;
    st[0] = 1;
    cyc(1);
    pulses(3);
    en = 1;
    irq_rst = 1;
    cyc(1);
    en = 0;
    irq_rst = 0;
    check("prio_ft", ft, 0);
    check("prio_irq", irq, 0);
    check("prio_reload", dut.count_q[0], 8'hFF);
    cyc(3);
    pulses(3);
    en = 1;
    cyc(1);
    en = 0;
    check("late_set", ft, 2'b01);
    check("late_irq", irq, 1);
    irq_rst = 1;
    cyc(1);
    irq_rst = 0;
    check("late_clr", ft, 0);
    cyc(2);
    pulses(4);
    check("allones_ovf", ft, 2'b01);
    st[0] = 0;
    cyc(1);
    reload[0] = 8'h80;
    st[0] = 1;
    cyc(1);
    check("mid_count", dut.count_q[0], 8'h80);
    check("mid_ft", ft, 2'b01);
    reset = 1;
    cyc(1);
    check("mrst_ft", ft, 0);
    check("mrst_status", status, 0);
    check("mrst_irq_n", irq_n, 1);
    check("mrst_count", dut.count_q[0], 0);
    reset = 0;
    cyc(1);
    check("mrst_reload", dut.count_q[0], 8'h80);
    pulses(3);
    check("presc_rst_3", dut.count_q[0], 8'h80);
    pulses(1);
    check("presc_rst_4", dut.count_q[0], 8'h81);
    cyc(2);
    r4 = 0;
    st4 = 4'hF;
    cyc(1);
    en4 = 1;
    cyc(3);
    check("s_p3", status4, 8'h00);
    cyc(1);
    check("s_p4", status4, 8'hC0);
    cyc(12);
    check("s_p16", status4, 8'hE0);
    cyc(48);
    check("s_p64", status4, 8'hF0);
    cyc(191);
    check("s_p255", status4, 8'hF0);
    cyc(1);
    check("s_p256", status4, 8'hF8);
    check("s_ft", ft4, 4'hF);
    en4 = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
